// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, idle column pattern and row decoder for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  typedef struct packed {
    logic       single;
    logic [1:0] idx;
  } row_dec_t;
  localparam logic [3:0] COL_IDLE = 4'b1110;
  // Exactly one low row gives its index; none or several low rows clear the single flag.
  function automatic row_dec_t row_decode(input logic [3:0] r);
    row_dec_t d;
    d.single = 1'b1;
    d.idx    = 2'd0;
    case (r)
      4'b1110: d.idx = 2'd0;
      4'b1101: d.idx = 2'd1;
      4'b1011: d.idx = 2'd2;
      4'b0111: d.idx = 2'd3;
      default: d.single = 1'b0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/keypad_entry_sync2.sv
// sync2: 4-bit two-flop synchroniser, resets to all-ones (keys released)
// Ports: clk, rst_n (async active-low), d (asynchronous input), q (synchronised output)
module sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= '1;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 hex keypad scanner, debouncer and 32-bit digit entry register
// Ports: clk, rst_n (async active-low), row (active-low, async), clr (sync clear of data/digits),
//        col (active-low strobes), data (newest digit in [3:0]), key_code, key_valid (pulse), digits (0..8)
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 150000,
  parameter int DEBOUNCE_CNT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [31:0] data,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [3:0]  digits
);
  localparam int CW = $clog2(SCAN_DIV > DEBOUNCE_CNT ? SCAN_DIV : DEBOUNCE_CNT);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    col_idx, col_idx_n;
  logic [3:0]    pat, pat_n, row_s, code_n, digits_n;
  logic [31:0]   data_n;
  logic          valid_n;
  row_dec_t      dec;
  sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(row), .q(row_s));
  assign dec = row_decode(row_s);
  assign col = ~(~COL_IDLE << col_idx);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= '0;
      pat       <= '1;
      data      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      digits    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      col_idx   <= col_idx_n;
      pat       <= pat_n;
      data      <= data_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      digits    <= digits_n;
    end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    col_idx_n = col_idx;
    pat_n     = pat;
    code_n    = key_code;
    valid_n   = 1'b0;
    data_n    = data;
    digits_n  = digits;
    case (state)
      SCAN:
        if (cnt == SCAN_LAST) begin
          cnt_n     = '0;
          pat_n     = row_s;
          state_n   = dec.single ? DEBOUNCE : SCAN;
          col_idx_n = dec.single ? col_idx : col_idx + 2'd1;
        end
      DEBOUNCE:
        if (row_s != pat) begin
          cnt_n     = '0;
          state_n   = SCAN;
          col_idx_n = col_idx + 2'd1;
        end else if (cnt == DB_LAST) begin
          cnt_n    = '0;
          state_n  = HELD;
          valid_n  = 1'b1;
          code_n   = {dec.idx, col_idx};
          data_n   = {data[27:0], dec.idx, col_idx};
          digits_n = (digits == 4'd8) ? 4'd8 : digits + 4'd1;
        end
      HELD: begin
        cnt_n   = '0;
        state_n = (row_s == 4'hF) ? RELEASE : HELD;
      end
      RELEASE:
        if (row_s != 4'hF) begin
          cnt_n   = '0;
          state_n = HELD;
        end else if (cnt == DB_LAST) begin
          cnt_n     = '0;
          state_n   = SCAN;
          col_idx_n = col_idx + 2'd1;
        end
    endcase
    // clear wins over a simultaneous acceptance; the key report itself is kept
    if (clr) begin
      data_n   = '0;
      digits_n = '0;
    end
  end
endmodule
